// File: rtl/usr_serial_rx.sv
// usr_serial_rx: serial-to-parallel receiver for the universal shift register.
// Strobed bits (s_valid) are collected into WIDTH-bit words in either LSB-first
// or MSB-first order. A finished word moves into a separate output holding
// register with a valid/ready handshake, so the next word can be collected
// while the consumer still holds off the previous one.
module usr_serial_rx #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_din,
  input  logic             s_valid,
  input  logic             s_sof,
  input  logic             dir,
  input  logic             p_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  // Collection stage
  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic               w_done;

  // Output holding stage
  logic [WIDTH-1:0]   r_dout;
  logic               r_pvalid;
  logic               r_ovr;

  // Bit placement helpers
  logic               w_start;   // this bit opens a new word
  logic               w_ldir;    // order that applies to this bit
  logic [CNT_W-1:0]   w_k;       // index of this bit within its word
  logic [CNT_W-1:0]   w_pos;     // destination bit position
  logic [WIDTH-1:0]   w_base;    // word before this bit is placed
  logic [WIDTH-1:0]   w_word;    // word after this bit is placed
  logic               w_blocked; // word finishes while output is still held

  // Where does the incoming bit go? A start (from IDLE or an s_sof restart)
  // begins from an empty word with freshly sampled dir; an append uses the
  // latched order so dir changes mid-word are ignored.
  always_comb begin
    w_start = s_valid && ((r_state == ST_IDLE) || s_sof);
    w_ldir  = w_start ? dir : r_dir;
    w_k     = w_start ? '0 : r_cnt;
    w_base  = w_start ? '0 : r_shift;
    w_pos   = w_ldir ? (LAST_IDX - w_k) : w_k;
    w_word  = w_base;
    for (int k = 0; k < WIDTH; k++) begin
      if (w_pos == CNT_W'(k)) w_word[k] = s_din;
    end
  end

  // Next-state logic for the collection FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Any strobed bit opens a word, s_sof or not.
        if (s_valid) begin
          w_dir_nxt   = dir;
          w_shift_nxt = w_word;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (s_valid && s_sof) begin
          // Resync: drop the partial word and restart at bit 0.
          w_dir_nxt   = dir;
          w_shift_nxt = w_word;
          w_cnt_nxt   = CNT_W'(1);
        end else if (s_valid) begin
          w_shift_nxt = w_word;
          if (r_cnt == LAST_IDX) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Collection FSM state and partial-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign w_blocked = w_done && r_pvalid && !p_ready;

  // Output holding register: load on completion if the slot is free (or
  // being drained this cycle), otherwise drop the word and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout   <= '0;
      r_pvalid <= 1'b0;
    end else if (w_done && (!r_pvalid || p_ready)) begin
      r_dout   <= w_word;
      r_pvalid <= 1'b1;
    end else if (r_pvalid && p_ready) begin
      r_pvalid <= 1'b0;
    end
  end

  // Sticky overrun; a set in the same cycle as clr_ovr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_blocked) begin
      r_ovr <= 1'b1;
    end else if (clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign p_dout  = r_dout;
  assign p_valid = r_pvalid;
  assign busy    = (r_state == ST_SHIFT);
  assign bit_cnt = r_cnt;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Bench for usr_serial_rx: directed scenarios followed by random traffic,
// every cycle compared against a queue-based word model.
module tb_usr_serial_rx;
  localparam int W  = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, s_din, s_valid, s_sof, dir, p_ready, clr_ovr;
  logic [W-1:0]  p_dout;
  logic          p_valid, busy, overrun;
  logic [CW-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: the bits of the current partial word in arrival
  // order, the order they were started with, and the output slot.
  bit           bq[$];
  bit           mdir;
  logic [W-1:0] m_dout;
  bit           m_pv;
  bit           m_ovr;

  always #5 clk = ~clk;

  usr_serial_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s_din(s_din), .s_valid(s_valid), .s_sof(s_sof),
    .dir(dir), .p_ready(p_ready), .clr_ovr(clr_ovr), .p_dout(p_dout),
    .p_valid(p_valid), .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit           done;
    bit           blocked;
    logic [W-1:0] w;
    done = 0;
    w    = '0;
    if (rst) begin
      bq.delete();
      m_dout = '0;
      m_pv   = 0;
      m_ovr  = 0;
      return;
    end
    if (s_valid) begin
      if (bq.size() == 0 || s_sof) begin
        bq.delete();
        mdir = dir;
      end
      bq.push_back(s_din);
      if (bq.size() == W) begin
        for (int k = 0; k < W; k++)
          if (bq[k]) w[mdir ? (W - 1 - k) : k] = 1'b1;
        bq.delete();
        done = 1;
      end
    end
    blocked = done && m_pv && !p_ready;
    if (done && !blocked) begin
      m_dout = w;
      m_pv   = 1;
    end else if (m_pv && p_ready) begin
      m_pv = 0;
    end
    if (blocked) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit d, input bit sof,
                      input bit dr, input bit rdy, input bit clr);
    rst = r; s_valid = v; s_din = d; s_sof = sof; dir = dr; p_ready = rdy; clr_ovr = clr;
    model_edge();
    @(posedge clk);
    #1;
    chk("p_dout",  32'(p_dout),  32'(m_dout));
    chk("p_valid", 32'(p_valid), 32'(m_pv));
    chk("busy",    32'(busy),    32'(bq.size() != 0));
    chk("bit_cnt", 32'(bit_cnt), 32'(bq.size()));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic bitv(input bit d, input bit sof, input bit dr, input bit rdy);
    step(0, 1, d, sof, dr, rdy, 0);
  endtask

  task automatic idle(input bit rdy, input bit clr);
    step(0, 0, 0, 0, 0, rdy, clr);
  endtask

  initial begin
    rst = 1; s_valid = 0; s_din = 0; s_sof = 0; dir = 0; p_ready = 0; clr_ovr = 0;
    mdir = 0; m_dout = '0; m_pv = 0; m_ovr = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pvalid", 32'(p_valid), 32'd0);
    chk("rst_busy",   32'(busy),    32'd0);

    // 1. LSB-first 1,0,1,1 -> D, one-cycle valid pulse
    bitv(1, 0, 0, 1); chk("t1_cnt1", 32'(bit_cnt), 32'd1);
    bitv(0, 0, 0, 1); chk("t1_cnt2", 32'(bit_cnt), 32'd2);
    bitv(1, 0, 0, 1); chk("t1_cnt3", 32'(bit_cnt), 32'd3);
    bitv(1, 0, 0, 1);
    chk("t1_dout",  32'(p_dout),  32'hD);
    chk("t1_valid", 32'(p_valid), 32'd1);
    chk("t1_busy",  32'(busy),    32'd0);
    chk("t1_cnt0",  32'(bit_cnt), 32'd0);
    idle(1, 0);
    chk("t1_pulse", 32'(p_valid), 32'd0);

    // 2. MSB-first with gaps, dir toggled mid-word -> B
    bitv(1, 0, 1, 1); idle(1, 0); idle(1, 0);
    bitv(0, 0, 0, 1); idle(1, 0);
    bitv(1, 0, 0, 1); idle(1, 0);
    bitv(1, 0, 1, 1);
    chk("t2_dout", 32'(p_dout), 32'hB);
    idle(1, 0);

    // 3. Back-pressure: 3 held, 5 dropped, overrun set then cleared
    bitv(1, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(0, 0, 0, 0);
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 0, 0, 0);
    chk("t3_dout", 32'(p_dout),  32'h3);
    chk("t3_ovr",  32'(overrun), 32'd1);
    idle(1, 0);
    chk("t3_drain", 32'(p_valid), 32'd0);
    idle(0, 1);
    chk("t3_clr", 32'(overrun), 32'd0);

    // 4. Completion in the same cycle as a transfer: A then 6
    bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0);
    chk("t4_a", 32'(p_dout), 32'hA);
    bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 0, 0, 1);
    chk("t4_dout",  32'(p_dout),  32'h6);
    chk("t4_valid", 32'(p_valid), 32'd1);
    chk("t4_ovr",   32'(overrun), 32'd0);
    idle(1, 0);

    // 5. Resync on s_sof after two bits -> 8
    bitv(1, 0, 0, 1); bitv(1, 0, 0, 1);
    bitv(0, 1, 0, 1); bitv(0, 0, 0, 1); bitv(0, 0, 0, 1); bitv(1, 0, 0, 1);
    chk("t5_dout", 32'(p_dout),  32'h8);
    chk("t5_ovr",  32'(overrun), 32'd0);
    idle(1, 0);

    // 6. Reset mid-word, then 1,1,1,1 -> F
    bitv(1, 0, 0, 1); bitv(0, 0, 0, 1); bitv(1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t6_busy", 32'(busy),    32'd0);
    chk("t6_cnt",  32'(bit_cnt), 32'd0);
    bitv(1, 0, 0, 1); bitv(1, 0, 0, 1); bitv(1, 0, 0, 1); bitv(1, 0, 0, 1);
    chk("t6_dout", 32'(p_dout), 32'hF);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 9) == 0),
           1'($urandom),
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
